// File: rtl/fsb_pkg.sv
// Shared types and defaults for the fast-side bus cycle controller and its refresh scheduler.
package fsb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } fsb_state_t;

    localparam int unsigned FSB_TIMEOUT_DEF      = 255;
    localparam int unsigned FSB_REF_PERIOD_DEF   = 256;
    localparam int unsigned FSB_REF_URGENT_DEF   = 128;
    localparam int unsigned FSB_REF_MAX_PEND_DEF = 3;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned fsb_cw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsb_refresh_sched.sv
// Refresh tick generator with saturating refresh-debt counter; shared by fast and slow controllers.
module fsb_refresh_sched
    import fsb_pkg::*;
#(
    parameter int unsigned PERIOD   = FSB_REF_PERIOD_DEF,
    parameter int unsigned URGENT   = FSB_REF_URGENT_DEF,
    parameter int unsigned MAX_PEND = FSB_REF_MAX_PEND_DEF
) (
    input  logic       FCLK,
    input  logic       nRESET,
    input  logic       RefAck,
    output logic       RefReq,
    output logic       RefUrgent,
    output logic [2:0] RefPend
);

    localparam int unsigned   CW       = fsb_cw(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [2:0]    PEND_MAX = 3'(MAX_PEND);

    logic [CW-1:0] RefCnt;
    logic          tick;

    assign tick = (RefCnt == CNT_LAST);

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET)
            RefCnt <= '0;
        else if (tick)
            RefCnt <= '0;
        else
            RefCnt <= RefCnt + CW'(1);
    end

    // A tick and an ack on the same edge cancel out.
    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET)
            RefPend <= 3'd0;
        else if (tick && !RefAck) begin
            if (RefPend < PEND_MAX)
                RefPend <= RefPend + 3'd1;
        end else if (RefAck && !tick) begin
            if (RefPend != 3'd0)
                RefPend <= RefPend - 3'd1;
        end
    end

    assign RefReq    = (RefPend != 3'd0);
    assign RefUrgent = (RefPend >= 3'd2) ||
                       ((RefPend == 3'd1) && (32'(RefCnt) >= URGENT));

endmodule

// File: rtl/fsb_cycle_ctrl.sv
// Fast-side bus cycle controller: AS detection, DTACK/VPA generation, watchdog BERR, refresh scheduling.
module fsb_cycle_ctrl
    import fsb_pkg::*;
#(
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned TIMEOUT_CYCLES = FSB_TIMEOUT_DEF,
    parameter int unsigned REF_PERIOD     = FSB_REF_PERIOD_DEF,
    parameter int unsigned REF_URGENT     = FSB_REF_URGENT_DEF,
    parameter int unsigned REF_MAX_PEND   = FSB_REF_MAX_PEND_DEF
) (
    input  logic       FCLK,
    input  logic       nRESET,
    input  logic       nAS,
    input  logic       IOCS,
    input  logic       FCS,
    input  logic       Ready,
    input  logic       IACS,
    input  logic       nBERRMac,
    input  logic       RefAck,
    input  logic       BERRClr,
    output logic       nDTACK,
    output logic       nVPA,
    output logic       nBERR,
    output logic       ASActive,
    output logic       ASInactive,
    output logic       RefReq,
    output logic       RefUrgent,
    output logic [2:0] RefPend,
    output logic       BERRFlag
);

    localparam int unsigned   WW       = fsb_cw(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WAIT_TO  = WW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

    fsb_state_t    state;
    logic          ASrf;
    logic [WW-1:0] WaitCnt;
    logic          ws_ok, ack_ok, to_hit, go_berr;

    assign ASActive   = ~nAS;
    assign ASInactive = nAS & ~ASrf;

    // Falling-edge sample lets ASInactive ignore a strobe that only just rose.
    always_ff @(negedge FCLK or negedge nRESET) begin
        if (!nRESET)
            ASrf <= 1'b0;
        else
            ASrf <= ~nAS;
    end

    generate
        if (WAIT_STATES == 0) begin : g_nows
            assign ws_ok = 1'b1;
        end else begin : g_ws
            assign ws_ok = (32'(WaitCnt) >= WAIT_STATES);
        end
    endgenerate

    // PDS-bound cycles are never timed out here; the PDS terminates them.
    assign ack_ok  = Ready && ws_ok;
    assign to_hit  = TO_EN && (WaitCnt == WAIT_TO) && FCS && !IOCS;
    assign go_berr = !ASInactive && (state == WAIT) && !ack_ok && to_hit;

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            WaitCnt <= '0;
            nDTACK  <= 1'b1;
            nVPA    <= 1'b1;
        end else if (ASInactive) begin
            state  <= IDLE;
            nDTACK <= 1'b1;
            nVPA   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ASActive) begin
                        state   <= WAIT;
                        WaitCnt <= '0;
                    end
                end
                WAIT: begin
                    if (WaitCnt != WAIT_SAT)
                        WaitCnt <= WaitCnt + WW'(1);
                    if (ack_ok) begin
                        state  <= ACK;
                        nDTACK <= IACS;
                        nVPA   <= ~IACS;
                    end else if (to_hit) begin
                        state <= BERR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET)
            BERRFlag <= 1'b0;
        else if (go_berr)
            BERRFlag <= 1'b1;
        else if (BERRClr)
            BERRFlag <= 1'b0;
    end

    assign nBERR = ~(~nAS && ((state == BERR) ||
                              (IOCS && ~nBERRMac && (~nDTACK || ~nVPA))));

    fsb_refresh_sched #(
        .PERIOD   (REF_PERIOD),
        .URGENT   (REF_URGENT),
        .MAX_PEND (REF_MAX_PEND)
    ) u_ref (
        .FCLK      (FCLK),
        .nRESET    (nRESET),
        .RefAck    (RefAck),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .RefPend   (RefPend)
    );

endmodule

// File: tb/tb_fsb_cycle_ctrl.sv
// Scoreboard bench: instance a has no wait states and an 8-edge watchdog, instance b has 3 wait states.
module tb_fsb_cycle_ctrl;

    logic FCLK = 1'b0;
    logic nRESET, nAS, IOCS, FCS, Ready, IACS, nBERRMac, RefAck, BERRClr;

    logic a_nDTACK, a_nVPA, a_nBERR, a_ASActive, a_ASInactive, a_RefReq, a_RefUrgent, a_BERRFlag;
    logic b_nDTACK, b_nVPA, b_nBERR, b_ASActive, b_ASInactive, b_RefReq, b_RefUrgent, b_BERRFlag;
    logic [2:0] a_RefPend, b_RefPend;

    always #5 FCLK = ~FCLK;

    fsb_cycle_ctrl #(
        .WAIT_STATES(0), .TIMEOUT_CYCLES(8), .REF_PERIOD(16), .REF_URGENT(8), .REF_MAX_PEND(3)
    ) u_a (
        .FCLK(FCLK), .nRESET(nRESET), .nAS(nAS), .IOCS(IOCS), .FCS(FCS), .Ready(Ready),
        .IACS(IACS), .nBERRMac(nBERRMac), .RefAck(RefAck), .BERRClr(BERRClr),
        .nDTACK(a_nDTACK), .nVPA(a_nVPA), .nBERR(a_nBERR), .ASActive(a_ASActive),
        .ASInactive(a_ASInactive), .RefReq(a_RefReq), .RefUrgent(a_RefUrgent),
        .RefPend(a_RefPend), .BERRFlag(a_BERRFlag)
    );

    fsb_cycle_ctrl #(
        .WAIT_STATES(3), .TIMEOUT_CYCLES(255), .REF_PERIOD(16), .REF_URGENT(8), .REF_MAX_PEND(3)
    ) u_b (
        .FCLK(FCLK), .nRESET(nRESET), .nAS(nAS), .IOCS(IOCS), .FCS(FCS), .Ready(Ready),
        .IACS(IACS), .nBERRMac(nBERRMac), .RefAck(RefAck), .BERRClr(BERRClr),
        .nDTACK(b_nDTACK), .nVPA(b_nVPA), .nBERR(b_nBERR), .ASActive(b_ASActive),
        .ASInactive(b_ASInactive), .RefReq(b_RefReq), .RefUrgent(b_RefUrgent),
        .RefPend(b_RefPend), .BERRFlag(b_BERRFlag)
    );

    typedef struct {
        string       tag;
        int unsigned exp;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;
    int  ecnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int unsigned exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_t e;
        if (sbq.size() == 0)
            chk("sb_empty", sbq.size(), 1);
        else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge FCLK);
        #1;
        ecnt++;
    endtask

    task automatic at(input int k);
        while (ecnt < k) tick();
    endtask

    task automatic ack_pulse();
        RefAck = 1'b1;
        tick();
        RefAck = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        nRESET = 1'b0; nAS = 1'b1; IOCS = 1'b0; FCS = 1'b0; Ready = 1'b0;
        IACS = 1'b0; nBERRMac = 1'b1; RefAck = 1'b0; BERRClr = 1'b0;

        // reset state
        sb_push("rst_dtack", 1); sb_push("rst_vpa", 1); sb_push("rst_berr", 1);
        sb_push("rst_req", 0); sb_push("rst_urg", 0); sb_push("rst_pend", 0);
        sb_push("rst_flag", 0); sb_push("rst_asact", 0); sb_push("rst_asinact", 1);
        tick(); tick();
        sb_pop(a_nDTACK); sb_pop(a_nVPA); sb_pop(a_nBERR);
        sb_pop(a_RefReq); sb_pop(a_RefUrgent); sb_pop(a_RefPend);
        sb_pop(a_BERRFlag); sb_pop(a_ASActive); sb_pop(a_ASInactive);

        nRESET = 1'b1;
        ecnt = 0;

        // refresh debt accumulation: ticks on edges 16, 32, 48, ...
        sb_push("ref15_pend", 0); sb_push("ref15_req", 0);
        at(15); sb_pop(a_RefPend); sb_pop(a_RefReq);
        sb_push("ref16_pend", 1); sb_push("ref16_req", 1); sb_push("ref16_urg", 0);
        at(16); sb_pop(a_RefPend); sb_pop(a_RefReq); sb_pop(a_RefUrgent);
        sb_push("ref23_urg", 0);
        at(23); sb_pop(a_RefUrgent);
        sb_push("ref24_urg", 1);
        at(24); sb_pop(a_RefUrgent);
        sb_push("ref32_pend", 2); sb_push("ref32_urg", 1);
        at(32); sb_pop(a_RefPend); sb_pop(a_RefUrgent);
        sb_push("ref48_pend", 3);
        at(48); sb_pop(a_RefPend);
        sb_push("ref64_sat", 3); sb_push("ref64_urg", 1);
        at(64); sb_pop(a_RefPend); sb_pop(a_RefUrgent);

        sb_push("ack1_pend", 2);
        ack_pulse(); sb_pop(a_RefPend);
        tick();
        sb_push("ack2_pend", 1);
        ack_pulse(); sb_pop(a_RefPend);
        tick();
        sb_push("ack3_pend", 0); sb_push("ack3_req", 0); sb_push("ack3_urg", 0);
        ack_pulse(); sb_pop(a_RefPend); sb_pop(a_RefReq); sb_pop(a_RefUrgent);
        tick();
        sb_push("ack_idle_pend", 0);
        ack_pulse(); sb_pop(a_RefPend);

        sb_push("ref80_pend", 1); sb_push("ref80_urg", 0);
        at(80); sb_pop(a_RefPend); sb_pop(a_RefUrgent);
        sb_push("ref88_urg", 1);
        at(88); sb_pop(a_RefUrgent);
        at(95);
        sb_push("tick_ack_pend", 1);
        ack_pulse(); sb_pop(a_RefPend);

        // reset mid-cycle, with nDTACK low and refresh debt outstanding
        nAS = 1'b0; FCS = 1'b1; Ready = 1'b1;
        sb_push("mrst_pre_dtack", 0); sb_push("mrst_pre_pend", 1);
        tick(); tick();
        sb_pop(a_nDTACK); sb_pop(a_RefPend);
        sb_push("mrst_dtack", 1); sb_push("mrst_vpa", 1);
        sb_push("mrst_pend", 0); sb_push("mrst_req", 0);
        nRESET = 1'b0;
        #1;
        sb_pop(a_nDTACK); sb_pop(a_nVPA); sb_pop(a_RefPend); sb_pop(a_RefReq);
        nAS = 1'b1; Ready = 1'b0;
        tick(); tick();
        nRESET = 1'b1;
        tick();

        // basic cycle: nAS low for 4 clocks
        nAS = 1'b0; FCS = 1'b1; Ready = 1'b1;
        sb_push("bas_asact", 1); sb_push("bas_asinact", 0);
        #1; sb_pop(a_ASActive); sb_pop(a_ASInactive);
        sb_push("bas_e1_dtack", 1);
        tick(); sb_pop(a_nDTACK);
        sb_push("bas_e2_dtack", 0); sb_push("bas_e2_vpa", 1); sb_push("bas_e2_berr", 1);
        tick(); sb_pop(a_nDTACK); sb_pop(a_nVPA); sb_pop(a_nBERR);
        sb_push("bas_e4_dtack", 0);
        tick(); tick(); sb_pop(a_nDTACK);
        nAS = 1'b1;
        sb_push("bas_end_dtack", 1); sb_push("bas_end_vpa", 1);
        tick(); sb_pop(a_nDTACK); sb_pop(a_nVPA);
        tick();

        // wait states on instance b: acknowledge on the 4th edge in WAIT
        nAS = 1'b0;
        tick();
        sb_push("ws_a_dtack", 0);
        tick(); sb_pop(a_nDTACK);
        sb_push("ws_b_e3_dtack", 1);
        tick(); tick(); sb_pop(b_nDTACK);
        sb_push("ws_b_e4_dtack", 0); sb_push("ws_b_vpa", 1); sb_push("ws_b_berr", 1);
        tick(); sb_pop(b_nDTACK); sb_pop(b_nVPA); sb_pop(b_nBERR);
        nAS = 1'b1;
        sb_push("ws_b_end_dtack", 1);
        tick(); sb_pop(b_nDTACK);
        tick();

        // interrupt acknowledge
        IACS = 1'b1; nAS = 1'b0;
        sb_push("iack_vpa", 0); sb_push("iack_dtack", 1); sb_push("iack_berr", 1);
        tick(); tick(); sb_pop(a_nVPA); sb_pop(a_nDTACK); sb_pop(a_nBERR);
        nAS = 1'b1;
        sb_push("iack_end_vpa", 1);
        tick(); sb_pop(a_nVPA);
        IACS = 1'b0;
        tick();

        // watchdog timeout on a fast cycle; BERRClr concurrent with entry loses
        Ready = 1'b0; FCS = 1'b1; IOCS = 1'b0; nAS = 1'b0;
        sb_push("to_e8_berr", 1); sb_push("to_e8_flag", 0);
        repeat (8) tick();
        sb_pop(a_nBERR); sb_pop(a_BERRFlag);
        BERRClr = 1'b1;
        sb_push("to_e9_berr", 0); sb_push("to_setwins_flag", 1); sb_push("to_e9_dtack", 1);
        tick(); sb_pop(a_nBERR); sb_pop(a_BERRFlag); sb_pop(a_nDTACK);
        BERRClr = 1'b0;
        sb_push("to_hold_berr", 0);
        tick(); sb_pop(a_nBERR);
        nAS = 1'b1;
        sb_push("to_asrise_berr", 1);
        #1; sb_pop(a_nBERR);
        sb_push("to_sticky_flag", 1);
        tick(); sb_pop(a_BERRFlag);
        BERRClr = 1'b1;
        sb_push("to_clr_flag", 0);
        tick(); sb_pop(a_BERRFlag);
        BERRClr = 1'b0;
        tick();

        // IOCS cycle never times out; Mac bus error passes through with the acknowledge
        IOCS = 1'b1; FCS = 1'b0; Ready = 1'b0; nAS = 1'b0;
        sb_push("io_berr", 1); sb_push("io_flag", 0); sb_push("io_dtack", 1);
        repeat (12) tick();
        sb_pop(a_nBERR); sb_pop(a_BERRFlag); sb_pop(a_nDTACK);
        Ready = 1'b1; nBERRMac = 1'b0;
        sb_push("io_ack_dtack", 0); sb_push("io_mac_berr", 0);
        tick(); sb_pop(a_nDTACK); sb_pop(a_nBERR);
        nAS = 1'b1;
        sb_push("io_asrise_berr", 1);
        #1; sb_pop(a_nBERR);
        tick(); tick();
        nBERRMac = 1'b1; IOCS = 1'b0; Ready = 1'b0;

        chk("sb_left", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
